lsu_queue: RTL and testbench

- Parametrised in-order load/store queue between decode/ALU and the L1 data cache.
- Decode reserves entries in program order with LOAD/STORE. The ALU later supplies the address (ADDR) and, for stores, the data (DATA), tagged by entry index.
- The head entry is issued to L1 once its operands are complete. Load results are written back tagged; stores retire on request acceptance.
- Generalises the fixed 64-bit LSU op model to configurable width and depth, and adds real queueing, a memory handshake and writeback.

---
 rtl/lsu_queue.sv | 195 +++++++++++++++++++
 tb/tb_lsu_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_queue.sv
// In-order load/store queue between decode/ALU and the L1 data cache.
// Optional misalignment exception path enabled by defining LSU_ALIGN_CHECK_EN.
module lsu_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic              alloc_is_store,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              fill_valid,
  input  logic              fill_is_data,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [DATA_W-1:0] fill_value,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_store,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              wb_valid,
  output logic [TAG_W-1:0]  wb_tag,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_exc,
  output logic [TAG_W:0]    count
);

  localparam logic [TAG_W:0]  LP_FULL  = (TAG_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LP_AMASK = ADDR_W'(DATA_W/8 - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t              r_state, w_state_nxt;
  logic [DEPTH-1:0]    r_vld, r_st, r_ardy, r_drdy;
  logic [ADDR_W-1:0]   r_addr [DEPTH];
  logic [DATA_W-1:0]   r_data [DEPTH];
  logic [TAG_W-1:0]    r_head, r_tail;
  logic [TAG_W:0]      r_count;
  logic                r_req_store;
  logic [ADDR_W-1:0]   r_req_addr;
  logic [DATA_W-1:0]   r_req_data;
  logic                r_wb_valid;
  logic [TAG_W-1:0]    r_wb_tag;
  logic [DATA_W-1:0]   r_wb_data;

  logic w_alloc, w_head_rdy, w_misal, w_issue, w_retire, w_wb_load, w_wb_exc;
  logic w_fill_ok;

  assign alloc_ready = (r_count != LP_FULL);
  assign w_alloc     = alloc_valid && alloc_ready;
  assign w_fill_ok   = fill_valid && r_vld[fill_tag];
  assign w_head_rdy  = r_vld[r_head] && r_ardy[r_head] && (!r_st[r_head] || r_drdy[r_head]);

`ifdef LSU_ALIGN_CHECK_EN
  assign w_misal = (r_addr[r_head] & LP_AMASK) != '0;
`else
  assign w_misal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_retire    = 1'b0;
    w_wb_load   = 1'b0;
    w_wb_exc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_head_rdy) begin
          if (w_misal) begin
            // Misaligned head bypasses L1 and retires straight into an exception writeback.
            w_retire = 1'b1;
            w_wb_exc = 1'b1;
          end else begin
            w_issue     = 1'b1;
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          if (r_req_store) begin
            w_retire    = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          w_retire    = 1'b1;
          w_wb_load   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Entry control bits and queue pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld   <= '0;
      r_st    <= '0;
      r_ardy  <= '0;
      r_drdy  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_fill_ok) begin
        if (fill_is_data) r_drdy[fill_tag] <= 1'b1;
        else              r_ardy[fill_tag] <= 1'b1;
      end
      if (w_alloc) begin
        r_vld[r_tail]  <= 1'b1;
        r_st[r_tail]   <= alloc_is_store;
        r_ardy[r_tail] <= 1'b0;
        r_drdy[r_tail] <= 1'b0;
        r_tail         <= r_tail + 1'b1;
      end
      if (w_retire) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + 1'b1;
      end
      case ({w_alloc, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill_ok) begin
      if (fill_is_data) r_data[fill_tag] <= fill_value;
      else              r_addr[fill_tag] <= ADDR_W'(fill_value);
    end
  end

  // Request and writeback output registers; request fields stay frozen while in REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_store <= 1'b0;
      r_req_addr  <= '0;
      r_req_data  <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_tag    <= '0;
      r_wb_data   <= '0;
    end else begin
      if (w_issue) begin
        r_req_store <= r_st[r_head];
        r_req_addr  <= r_addr[r_head];
        r_req_data  <= r_st[r_head] ? r_data[r_head] : '0;
      end
      r_wb_valid <= w_wb_load || w_wb_exc;
      if (w_wb_load || w_wb_exc) begin
        r_wb_tag  <= r_head;
        r_wb_data <= w_wb_load ? mem_resp_data : '0;
      end
    end
  end

`ifdef LSU_ALIGN_CHECK_EN
  logic r_wb_exc;
  always_ff @(posedge clk) begin
    if (rst) r_wb_exc <= 1'b0;
    else     r_wb_exc <= w_wb_exc;
  end
  assign wb_exc = r_wb_exc;
`else
  assign wb_exc = 1'b0;
`endif

  assign alloc_tag     = r_tail;
  assign mem_req_valid = (r_state == S_REQ);
  assign mem_req_store = r_req_store;
  assign mem_req_addr  = r_req_addr;
  assign mem_req_data  = r_req_data;
  assign wb_valid      = r_wb_valid;
  assign wb_tag        = r_wb_tag;
  assign wb_data       = r_wb_data;
  assign count         = r_count;

endmodule

// File: tb/tb_lsu_queue.sv
// Directed bench for lsu_queue (DEPTH=8, 64-bit address/data).
module tb_lsu_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid, alloc_is_store, alloc_ready;
  logic [2:0]  alloc_tag;
  logic        fill_valid, fill_is_data;
  logic [2:0]  fill_tag;
  logic [63:0] fill_value;
  logic        mem_req_valid, mem_req_ready, mem_req_store;
  logic [63:0] mem_req_addr, mem_req_data;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        wb_valid;
  logic [2:0]  wb_tag;
  logic [63:0] wb_data;
  logic        wb_exc;
  logic [3:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  lsu_queue #(.DEPTH(8), .ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_is_store(alloc_is_store),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .fill_valid(fill_valid), .fill_is_data(fill_is_data),
    .fill_tag(fill_tag), .fill_value(fill_value),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_store(mem_req_store), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .wb_exc(wb_exc), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic fill(input logic [2:0] t, input logic d, input logic [63:0] v);
    fill_valid = 1'b1; fill_is_data = d; fill_tag = t; fill_value = v;
    step();
    fill_valid = 1'b0;
  endtask

  initial begin
    alloc_valid = 0; alloc_is_store = 0; fill_valid = 0; fill_is_data = 0;
    fill_tag = 0; fill_value = 0; mem_req_ready = 0; mem_resp_valid = 0;
    mem_resp_data = 0;
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_exc", wb_exc, 0);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_req_addr", mem_req_addr, 0);

    // Fill the queue: tag 0 STORE, tags 1..7 LOAD.
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1; alloc_is_store = (i == 0);
      chk("alloc_tag", alloc_tag, 64'(i));
      chk("alloc_ready", alloc_ready, 1);
      step();
    end
    chk("full_count", count, 8);
    chk("full_ready", alloc_ready, 0);
    step();
    alloc_valid = 0;
    chk("full_count_hold", count, 8);
    chk("full_tail_hold", alloc_tag, 0);

    // Store tag 0, data delivered before address.
    fill(3'd0, 1'b1, 64'hDEAD);
    chk("st_no_req_data_only", mem_req_valid, 0);
    fill(3'd0, 1'b0, 64'h1000);
    chk("st_no_req_yet", mem_req_valid, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("st_req_valid", mem_req_valid, 1);
      chk("st_req_store", mem_req_store, 1);
      chk("st_req_addr", mem_req_addr, 64'h1000);
      chk("st_req_data", mem_req_data, 64'hDEAD);
      step();
    end
    mem_req_ready = 1;
    chk("st_req_valid_acc", mem_req_valid, 1);
    step();
    mem_req_ready = 0;
    chk("st_done_valid", mem_req_valid, 0);
    chk("st_count", count, 7);
    chk("st_ready", alloc_ready, 1);
    chk("st_no_wb", wb_valid, 0);

    // Load tag 1.
    fill(3'd1, 1'b0, 64'h2000);
    step();
    chk("ld_req_valid", mem_req_valid, 1);
    chk("ld_req_store", mem_req_store, 0);
    chk("ld_req_addr", mem_req_addr, 64'h2000);
    chk("ld_req_data", mem_req_data, 0);
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    chk("ld_wait_valid", mem_req_valid, 0);
    chk("ld_wait_no_wb", wb_valid, 0);
    mem_resp_valid = 1; mem_resp_data = 64'hCAFE;
    step();
    mem_resp_valid = 0;
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_wb_tag", wb_tag, 1);
    chk("ld_wb_data", wb_data, 64'hCAFE);
    chk("ld_count", count, 6);
    step();
    chk("ld_wb_once", wb_valid, 0);
    step();
    chk("ld_wb_once2", wb_valid, 0);

    // Tail wrap with 10 store entries.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      alloc_valid = 1; alloc_is_store = 1;
      chk("wrap_tag", alloc_tag, 64'(i % 8));
      step();
      alloc_valid = 0;
      fill(3'(i % 8), 1'b0, 64'h100 * i);
      fill(3'(i % 8), 1'b1, 64'h55 + i);
      step();
      chk("wrap_req_addr", mem_req_addr, 64'h100 * i);
      mem_req_ready = 1;
      step();
      mem_req_ready = 0;
      chk("wrap_count", count, 0);
    end
    alloc_valid = 1; alloc_is_store = 1;
    chk("wrap_tag10", alloc_tag, 2);
    step();
    alloc_valid = 0;
    fill(3'd2, 1'b0, 64'h4000);
    fill(3'd2, 1'b1, 64'h77);
    step();
    chk("sim_req_valid", mem_req_valid, 1);
    mem_req_ready = 1; alloc_valid = 1; alloc_is_store = 0;
    step();
    mem_req_ready = 0; alloc_valid = 0;
    chk("sim_count", count, 1);
    chk("sim_tail", alloc_tag, 4);

    // Reset while waiting for a load response.
    do_reset();
    alloc_valid = 1; alloc_is_store = 0;
    step();
    alloc_valid = 0;
    fill(3'd0, 1'b0, 64'h3000);
    step();
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    chk("rw_count_pre", count, 1);
    rst = 1; mem_resp_valid = 1; mem_resp_data = 64'hBEEF;
    step();
    rst = 0;
    chk("rw_count", count, 0);
    chk("rw_req_valid", mem_req_valid, 0);
    chk("rw_alloc_ready", alloc_ready, 1);
    step();
    mem_resp_valid = 0;
    chk("rw_no_wb", wb_valid, 0);
    step();
    chk("rw_no_wb2", wb_valid, 0);

    // Misaligned load.
    alloc_valid = 1; alloc_is_store = 0;
    step();
    alloc_valid = 0;
    fill(3'd0, 1'b0, 64'h1003);
    step();
`ifdef LSU_ALIGN_CHECK_EN
    chk("al_no_req", mem_req_valid, 0);
    chk("al_wb_valid", wb_valid, 1);
    chk("al_wb_exc", wb_exc, 1);
    chk("al_wb_data", wb_data, 0);
    chk("al_wb_tag", wb_tag, 0);
    chk("al_count", count, 0);
    step();
    chk("al_wb_once", wb_valid, 0);
`else
    chk("al_req_valid", mem_req_valid, 1);
    chk("al_req_addr", mem_req_addr, 64'h1003);
    chk("al_wb_exc", wb_exc, 0);
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    mem_resp_valid = 1; mem_resp_data = 64'h1234;
    step();
    mem_resp_valid = 0;
    chk("al_wb_valid", wb_valid, 1);
    chk("al_wb_exc_ld", wb_exc, 0);
    chk("al_wb_data", wb_data, 64'h1234);
    chk("al_count", count, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
